// File: rtl/count_sequencer.sv
// count_sequencer: round-robin sequencer that advances a bank of step
// counters through one shared adder, in bursts launched by start.
module count_sequencer #(
   parameter int unsigned NUM_CH  = 3,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned BURST_W = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       cfg_we,
   input  logic [$clog2(NUM_CH)-1:0]  cfg_idx,
   input  logic [WIDTH-1:0]           cfg_step,
   input  logic                       start,
   input  logic [BURST_W-1:0]         burst_len,
   input  logic                       abort,
   input  logic [NUM_CH-1:0]          req,
   output logic [NUM_CH-1:0]          grant,
   output logic [NUM_CH*WIDTH-1:0]    count,
   output logic                       busy,
   output logic                       done,
   output logic [BURST_W-1:0]         beats
);

   localparam int unsigned IDX_W = $clog2(NUM_CH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [BURST_W-1:0] len_q, len_d;
   logic [BURST_W-1:0] beats_q, beats_d;
   logic [BURST_W-1:0] beats_inc;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [WIDTH-1:0]   step_q  [NUM_CH];
   logic [WIDTH-1:0]   count_q [NUM_CH];

   logic               hit;
   logic [IDX_W-1:0]   gidx;
   logic [IDX_W-1:0]   cand;
   logic               grant_en;

   assign beats_inc = beats_q + BURST_W'(1);
   assign grant_en  = (state_q == S_RUN) && !abort && hit;

   // Round-robin search: first requesting channel at or above rr_q, wrapping
   always_comb begin
      hit  = 1'b0;
      gidx = '0;
      cand = '0;
      for (int unsigned off = 0; off < NUM_CH; off++) begin
         cand = IDX_W'((32'(rr_q) + off) % NUM_CH);
         if (!hit && req[cand]) begin
            hit  = 1'b1;
            gidx = cand;
         end
      end
   end

   // One-hot grant, only when a beat is actually consumed this cycle
   always_comb begin
      grant = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         grant[i] = grant_en && (gidx == IDX_W'(i));
      end
   end

   // Burst control: next state, burst length, beat count and rr pointer
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      beats_d = beats_q;
      rr_d    = rr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               beats_d = '0;
               if (burst_len != '0) begin
                  len_d   = burst_len;
                  state_d = S_RUN;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_DONE;
            end else if (grant_en) begin
               beats_d = beats_inc;
               rr_d    = (gidx == IDX_W'(NUM_CH - 1)) ? '0 : gidx + IDX_W'(1);
               if (beats_inc == len_q) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         beats_q <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         beats_q <= beats_d;
         rr_q    <= rr_d;
      end
   end

   // Step registers; the granted counter reads the old step in a write cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            step_q[i] <= WIDTH'(i + 1);
         end
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg_we && (cfg_idx == IDX_W'(i))) begin
               step_q[i] <= cfg_step;
            end
         end
      end
   end

   // Shared adder: only the granted counter advances, wrapping silently
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            count_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
               count_q[i] <= count_q[i] + step_q[i];
            end
         end
      end
   end

   // Pack the counter bank onto the flat output bus
   always_comb begin
      count = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         count[i*WIDTH +: WIDTH] = count_q[i];
      end
   end

   assign busy  = (state_q == S_RUN);
   assign done  = (state_q == S_DONE);
   assign beats = beats_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Testbench for count_sequencer: directed scenarios plus random traffic,
// checked each cycle against a behavioural model of bursts and counters.
module tb_count_sequencer;

   localparam int N = 3;
   localparam int W = 8;
   localparam int B = 8;

   logic             clk;
   logic             reset_n;
   logic             cfg_we;
   logic [1:0]       cfg_idx;
   logic [W-1:0]     cfg_step;
   logic             start;
   logic [B-1:0]     burst_len;
   logic             abort;
   logic [N-1:0]     req;
   logic [N-1:0]     grant;
   logic [N*W-1:0]   count;
   logic             busy;
   logic             done;
   logic [B-1:0]     beats;

   int n_vec;
   int n_err;

   // behavioural model
   int m_count [N];
   int m_step  [N];
   int m_rr;
   int m_len;
   int m_beats;
   bit m_run;
   bit m_done;

   count_sequencer #(.NUM_CH(N), .WIDTH(W), .BURST_W(B)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_step  (cfg_step),
      .start     (start),
      .burst_len (burst_len),
      .abort     (abort),
      .req       (req),
      .grant     (grant),
      .count     (count),
      .busy      (busy),
      .done      (done),
      .beats     (beats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_count[i] = 0;
         m_step[i]  = i + 1;
      end
      m_rr    = 0;
      m_len   = 0;
      m_beats = 0;
      m_run   = 0;
      m_done  = 0;
   endtask

   task automatic check_outputs(input string tag, input int exp_grant);
      chk({tag, ".grant"}, 32'(grant), 32'(exp_grant));
      chk({tag, ".busy"},  32'(busy),  32'(m_run));
      chk({tag, ".done"},  32'(done),  32'(m_done));
      chk({tag, ".beats"}, 32'(beats), 32'(m_beats));
      for (int i = 0; i < N; i++) begin
         chk({tag, ".count"}, 32'(count[i*W +: W]), 32'(m_count[i]));
      end
   endtask

   // One clock: drive at negedge, check before posedge, advance model at posedge
   task automatic do_cycle(input string tag, input bit we, input int idx, input int stp,
                           input bit st, input int len, input bit ab, input int rq);
      int g;
      @(negedge clk);
      cfg_we    = we;
      cfg_idx   = idx[1:0];
      cfg_step  = stp[W-1:0];
      start     = st;
      burst_len = len[B-1:0];
      abort     = ab;
      req       = rq[N-1:0];
      g = -1;
      if (m_run && !ab) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (g < 0 && ((rq >> c) & 1) == 1) g = c;
         end
      end
      #1;
      check_outputs(tag, (g >= 0) ? (1 << g) : 0);
      @(posedge clk);
      if (m_done) begin
         m_done = 0;
      end else if (m_run) begin
         if (ab) begin
            m_run  = 0;
            m_done = 1;
         end else if (g >= 0) begin
            m_count[g] = (m_count[g] + m_step[g]) % 256;
            m_beats    = m_beats + 1;
            m_rr       = (g + 1) % N;
            if (m_beats == m_len) begin
               m_run  = 0;
               m_done = 1;
            end
         end
      end else if (st) begin
         m_beats = 0;
         if (len != 0) begin
            m_run = 1;
            m_len = len;
         end else begin
            m_done = 1;
         end
      end
      if (we && idx < N) m_step[idx] = stp;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) do_cycle("idle", 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Assert reset between clock edges and confirm outputs clear without a clock
   task automatic mid_reset(input string tag);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs(tag, 0);
      @(negedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      reset_n   = 1'b0;
      cfg_we    = 1'b0;
      cfg_idx   = '0;
      cfg_step  = '0;
      start     = 1'b0;
      burst_len = '0;
      abort     = 1'b0;
      req       = '0;
      model_reset();
      #12;
      check_outputs("reset", 0);
      @(negedge clk);
      #1;
      reset_n = 1'b1;

      // 1: len=4 all requesting -> ch0,ch1,ch2,ch0
      do_cycle("t1", 0, 0, 0, 1, 4, 0, 7);
      for (int i = 0; i < 4; i++) do_cycle("t1", 0, 0, 0, 0, 0, 0, 7);
      do_cycle("t1d", 0, 0, 0, 0, 0, 0, 7);
      idle_cycles(1);
      chk("t1.cnt0", 32'(count[0 +: W]), 2);
      chk("t1.cnt1", 32'(count[W +: W]), 2);
      chk("t1.cnt2", 32'(count[2*W +: W]), 3);
      chk("t1.beats", 32'(beats), 4);

      // 2: only ch1 requests
      mid_reset("t2rst");
      do_cycle("t2", 0, 0, 0, 1, 3, 0, 2);
      for (int i = 0; i < 3; i++) do_cycle("t2", 0, 0, 0, 0, 0, 0, 2);
      idle_cycles(2);
      chk("t2.cnt1", 32'(count[W +: W]), 6);
      chk("t2.cnt0", 32'(count[0 +: W]), 0);

      // 3: step 200 on ch0; write during a grant cycle still uses old step
      mid_reset("t3rst");
      do_cycle("t3cfg", 1, 0, 200, 0, 0, 0, 0);
      do_cycle("t3", 0, 0, 0, 1, 2, 0, 1);
      do_cycle("t3", 0, 0, 0, 0, 0, 0, 1);
      do_cycle("t3w", 1, 0, 7, 0, 0, 0, 1);
      idle_cycles(2);
      chk("t3.cnt0", 32'(count[0 +: W]), 144);
      do_cycle("t3ign", 1, 3, 99, 1, 1, 0, 1);
      idle_cycles(2);

      // 4: abort in second RUN cycle
      mid_reset("t4rst");
      do_cycle("t4", 0, 0, 0, 1, 5, 0, 7);
      do_cycle("t4", 0, 0, 0, 0, 0, 0, 7);
      do_cycle("t4ab", 0, 0, 0, 0, 0, 1, 7);
      do_cycle("t4d", 0, 0, 0, 0, 0, 0, 7);
      chk("t4.beats", 32'(beats), 1);
      do_cycle("t4ab2", 0, 0, 0, 0, 0, 1, 7);

      // 5: reset mid-burst, steps return to defaults
      mid_reset("t5pre");
      do_cycle("t5", 1, 1, 50, 1, 10, 0, 7);
      for (int i = 0; i < 3; i++) do_cycle("t5", 0, 0, 0, 0, 0, 0, 7);
      mid_reset("t5rst");
      do_cycle("t5b", 0, 0, 0, 1, 3, 0, 7);
      for (int i = 0; i < 4; i++) do_cycle("t5b", 0, 0, 0, 0, 0, 0, 7);
      chk("t5.cnt1", 32'(count[W +: W]), 2);

      // 6: zero length, start while busy, stall on empty req
      do_cycle("t6z", 0, 0, 0, 1, 0, 0, 7);
      do_cycle("t6zd", 0, 0, 0, 1, 4, 0, 7);
      do_cycle("t6", 0, 0, 0, 1, 2, 0, 0);
      do_cycle("t6st", 0, 0, 0, 1, 9, 0, 0);
      do_cycle("t6st", 0, 0, 0, 0, 0, 0, 0);
      do_cycle("t6", 0, 0, 0, 1, 7, 0, 4);
      do_cycle("t6", 0, 0, 0, 0, 0, 0, 5);
      idle_cycles(2);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         do_cycle("rnd", ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 6)), ($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 7)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
